parking_lot_tracker: RTL and testbench

- Parametrised occupancy tracker for a single-gate-pair parking lot.
- Counts cars against a configurable capacity and logs accepted entries per hour into an internal log RAM.
- Detects the rush window: the hour the lot first fills and the hour it next empties.
- After the last hour it enters a review mode that steps through the log for the display layer, which maps outputs to HEX.

---
 rtl/parking_pkg.sv | 13 +
 rtl/parking_lot_tracker_if.sv | 34 +++
 rtl/parking_log_ram.sv | 42 ++++
 rtl/parking_lot_tracker.sv | 150 +++++++++++++++
 tb/tb_parking_lot_tracker.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding and saturating-increment helper for the parking lot tracker
package parking_pkg;

  typedef logic [0:0] state_t;

  localparam state_t S_RUN    = 1'b0;
  localparam state_t S_REVIEW = 1'b1;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/parking_lot_tracker_if.sv
// rtl/parking_lot_tracker_if.sv - gate/hour inputs and status/review outputs of the parking lot tracker
interface parking_lot_tracker_if #(
  parameter int CNT_W  = 2,
  parameter int HOUR_W = 3,
  parameter int LOG_W  = 4
);
  logic              entrance_gate;
  logic              exit_gate;
  logic              incrHour;
  logic [CNT_W-1:0]  occupancy;
  logic              isFull;
  logic              isEmpty;
  logic              entry_reject;
  logic [HOUR_W-1:0] hour;
  logic              done;
  logic              rush_seen;
  logic [HOUR_W-1:0] rush_start;
  logic              rush_end_seen;
  logic [HOUR_W-1:0] rush_end;
  logic [HOUR_W-1:0] log_addr;
  logic [LOG_W-1:0]  log_data;

  modport master (
    output entrance_gate, exit_gate, incrHour,
    input  occupancy, isFull, isEmpty, entry_reject, hour, done,
           rush_seen, rush_start, rush_end_seen, rush_end, log_addr, log_data
  );

  modport slave (
    input  entrance_gate, exit_gate, incrHour,
    output occupancy, isFull, isEmpty, entry_reject, hour, done,
           rush_seen, rush_start, rush_end_seen, rush_end, log_addr, log_data
  );
endinterface

// File: rtl/parking_log_ram.sv
// rtl/parking_log_ram.sv - per-hour entry log: synchronous write, registered read, array never reset
module parking_log_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/parking_lot_tracker.sv
// rtl/parking_lot_tracker.sv - occupancy counter, hourly entry logging, rush window capture and log review
module parking_lot_tracker
  import parking_pkg::*;
#(
  parameter  int CAPACITY    = 3,
  parameter  int NUM_HOURS   = 8,
  parameter  int LOG_W       = 4,
  parameter  int STEP_CYCLES = 1,
  localparam int CNT_W       = $clog2(CAPACITY + 1),
  localparam int HOUR_W      = $clog2(NUM_HOURS)
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_lot_tracker_if.slave  bus
);
  localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);
  localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(NUM_HOURS - 1);
  localparam logic [31:0]       LOG_MAX   = (32'd1 << LOG_W) - 32'd1;
  localparam int                DWELL_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(STEP_CYCLES - 1);

  state_t              state_d, state_q;
  logic [CNT_W-1:0]    occ_d, occ_q;
  logic [LOG_W-1:0]    cnt_d, cnt_q;
  logic [HOUR_W-1:0]   hour_d, hour_q;
  logic                reject_d, reject_q;
  logic                rush_seen_d, rush_seen_q;
  logic [HOUR_W-1:0]   rush_start_d, rush_start_q;
  logic                rush_end_seen_d, rush_end_seen_q;
  logic [HOUR_W-1:0]   rush_end_d, rush_end_q;
  logic [HOUR_W-1:0]   log_addr_d, log_addr_q;
  logic [DWELL_W-1:0]  dwell_d, dwell_q;

  logic                full, empty, entry_acc, exit_acc;
  logic [LOG_W-1:0]    cnt_inc;
  logic                wr_en, rd_en;

  always_comb begin
    state_d         = state_q;
    occ_d           = occ_q;
    cnt_d           = cnt_q;
    hour_d          = hour_q;
    reject_d        = 1'b0;
    rush_seen_d     = rush_seen_q;
    rush_start_d    = rush_start_q;
    rush_end_seen_d = rush_end_seen_q;
    rush_end_d      = rush_end_q;
    log_addr_d      = log_addr_q;
    dwell_d         = dwell_q;
    wr_en           = 1'b0;

    full      = (occ_q == CAP);
    empty     = (occ_q == '0);
    // A simultaneous exit frees the space, so a full lot still admits the entering car.
    entry_acc = bus.entrance_gate && (!full || bus.exit_gate);
    exit_acc  = bus.exit_gate && !empty;
    cnt_inc   = entry_acc ? LOG_W'(sat_inc(32'(cnt_q), LOG_MAX)) : cnt_q;

    if (state_q == S_RUN) begin
      reject_d = bus.entrance_gate && full && !bus.exit_gate;
      if (entry_acc && !exit_acc) begin
        occ_d = occ_q + CNT_W'(1);
      end else if (exit_acc && !entry_acc) begin
        occ_d = occ_q - CNT_W'(1);
      end
      cnt_d = cnt_inc;
      if (bus.incrHour) begin
        wr_en = 1'b1;
        cnt_d = '0;
        if (hour_q < LAST_HOUR) begin
          hour_d = hour_q + HOUR_W'(1);
        end else begin
          state_d = S_REVIEW;
        end
      end
      // Capture against the values that become visible next cycle so both fields line up with occupancy/hour.
      if (!rush_seen_q && occ_d == CAP) begin
        rush_seen_d  = 1'b1;
        rush_start_d = hour_d;
      end else if (rush_seen_q && !rush_end_seen_q && occ_d == '0) begin
        rush_end_seen_d = 1'b1;
        rush_end_d      = hour_d;
      end
    end else begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d    = '0;
        log_addr_d = (log_addr_q == LAST_HOUR) ? '0 : log_addr_q + HOUR_W'(1);
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end

    rd_en = (state_d == S_REVIEW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_RUN;
      occ_q           <= '0;
      cnt_q           <= '0;
      hour_q          <= '0;
      reject_q        <= 1'b0;
      rush_seen_q     <= 1'b0;
      rush_start_q    <= '0;
      rush_end_seen_q <= 1'b0;
      rush_end_q      <= '0;
      log_addr_q      <= '0;
      dwell_q         <= '0;
    end else begin
      state_q         <= state_d;
      occ_q           <= occ_d;
      cnt_q           <= cnt_d;
      hour_q          <= hour_d;
      reject_q        <= reject_d;
      rush_seen_q     <= rush_seen_d;
      rush_start_q    <= rush_start_d;
      rush_end_seen_q <= rush_end_seen_d;
      rush_end_q      <= rush_end_d;
      log_addr_q      <= log_addr_d;
      dwell_q         <= dwell_d;
    end
  end

  parking_log_ram #(
    .DEPTH (NUM_HOURS),
    .WIDTH (LOG_W),
    .AW    (HOUR_W)
  ) u_log_ram (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_en),
    .wr_addr (hour_q),
    .wr_data (cnt_inc),
    .rd_en   (rd_en),
    .rd_addr (log_addr_q),
    .rd_data (bus.log_data)
  );

  assign bus.occupancy     = occ_q;
  assign bus.isFull        = full;
  assign bus.isEmpty       = empty;
  assign bus.entry_reject  = reject_q;
  assign bus.hour          = hour_q;
  assign bus.done          = (state_q == S_REVIEW);
  assign bus.rush_seen     = rush_seen_q;
  assign bus.rush_start    = rush_start_q;
  assign bus.rush_end_seen = rush_end_seen_q;
  assign bus.rush_end      = rush_end_q;
  assign bus.log_addr      = log_addr_q;
endmodule

// File: tb/tb_parking_lot_tracker.sv
// tb/tb_parking_lot_tracker.sv - randomized scoreboard bench for parking_lot_tracker against a behavioural lot model
module tb_parking_lot_tracker;
  localparam int CAP = 3;
  localparam int NH  = 4;
  localparam int LW  = 4;
  localparam int SC  = 2;
  localparam int CW  = $clog2(CAP + 1);
  localparam int HW  = $clog2(NH);
  localparam int LOG_MAX = (1 << LW) - 1;

  typedef struct {
    int occ; int full; int empty; int rej; int hour; int done;
    int rs; int rstart; int res; int rend; int addr; int ldata;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   checks;
  int   errors;

  parking_lot_tracker_if #(.CNT_W(CW), .HOUR_W(HW), .LOG_W(LW)) bus ();

  parking_lot_tracker #(
    .CAPACITY(CAP), .NUM_HOURS(NH), .LOG_W(LW), .STEP_CYCLES(SC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural lot: plain counts, a log array and a review cursor.
  int m_occ, m_hour, m_cnt, m_review, m_rej;
  int m_rs, m_rstart, m_res, m_rend, m_addr, m_dwell, m_ldata;
  int m_log [NH];

  task automatic chk(input string name, input logic [31:0] act, input int exp_v);
    checks++;
    if (act !== 32'(exp_v)) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input bit r, input bit eg, input bit xg, input bit ih);
    exp_t e;
    int   in_ok, out_ok;
    @(negedge clk);
    reset             = r;
    bus.entrance_gate = eg;
    bus.exit_gate     = xg;
    bus.incrHour      = ih;
    if (r) begin
      m_occ = 0; m_hour = 0; m_cnt = 0; m_review = 0; m_rej = 0;
      m_rs = 0; m_rstart = 0; m_res = 0; m_rend = 0; m_addr = 0; m_dwell = 0; m_ldata = 0;
    end else if (m_review == 0) begin
      in_ok  = (eg && (m_occ < CAP || xg)) ? 1 : 0;
      out_ok = (xg && m_occ > 0) ? 1 : 0;
      m_rej  = (eg && m_occ == CAP && !xg) ? 1 : 0;
      m_occ  = m_occ + in_ok - out_ok;
      if (in_ok == 1 && m_cnt < LOG_MAX) m_cnt++;
      if (ih) begin
        m_log[m_hour] = m_cnt;
        m_cnt = 0;
        if (m_hour < NH - 1) m_hour++;
        else begin
          m_review = 1;
          m_ldata  = m_log[0];
        end
      end
      if (m_rs == 0 && m_occ == CAP) begin
        m_rs = 1; m_rstart = m_hour;
      end else if (m_rs == 1 && m_res == 0 && m_occ == 0) begin
        m_res = 1; m_rend = m_hour;
      end
    end else begin
      m_rej   = 0;
      m_ldata = m_log[m_addr];
      m_dwell++;
      if (m_dwell == SC) begin
        m_dwell = 0;
        m_addr  = (m_addr + 1) % NH;
      end
    end
    e.occ = m_occ; e.full = (m_occ == CAP); e.empty = (m_occ == 0); e.rej = m_rej;
    e.hour = m_hour; e.done = m_review; e.rs = m_rs; e.rstart = m_rstart;
    e.res = m_res; e.rend = m_rend; e.addr = m_addr; e.ldata = m_ldata;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("occupancy",     32'(bus.occupancy),     e.occ);
        chk("isFull",        32'(bus.isFull),        e.full);
        chk("isEmpty",       32'(bus.isEmpty),       e.empty);
        chk("entry_reject",  32'(bus.entry_reject),  e.rej);
        chk("hour",          32'(bus.hour),          e.hour);
        chk("done",          32'(bus.done),          e.done);
        chk("rush_seen",     32'(bus.rush_seen),     e.rs);
        chk("rush_start",    32'(bus.rush_start),    e.rstart);
        chk("rush_end_seen", 32'(bus.rush_end_seen), e.res);
        chk("rush_end",      32'(bus.rush_end),      e.rend);
        chk("log_addr",      32'(bus.log_addr),      e.addr);
        chk("log_data",      32'(bus.log_data),      e.ldata);
      end
    end
  end

  initial begin : driver
    int review_cycles;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.entrance_gate = 1'b0;
    bus.exit_gate     = 1'b0;
    bus.incrHour      = 1'b0;
    for (int i = 0; i < NH; i++) m_log[i] = 0;

    // Directed session
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
    end
    step(0, 1, 0, 1);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 12; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);

    // Randomized sessions, one of them interrupted by a mid-session reset
    for (int s = 0; s < 6; s++) begin
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      review_cycles = 0;
      for (int c = 0; c < 400 && review_cycles < 14; c++) begin
        if (s == 2 && c == 40) step(1, 0, 0, 0);
        else step(0, ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 99) < 7));
        if (m_review != 0) review_cycles++;
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
